ibuf_offset_cal: RTL and testbench
==================================

Name: ibuf_offset_cal

Overview:
- Calibration controller for the other end of the input-buffer offset-trim interface.
- Drives the buffer's 4-bit offset code (osc) and calibration enable (osc_en).
- Observes the buffer's output while its input is held at the reference level, and finds the trim code at which the comparator trips.
- Sits beside each calibrated IOBUF in the DDR PHY. After calibration it holds the chosen code and releases osc_en for normal operation.

Parameters:
- SETTLE_CYCLES, 8: cycles to wait after each code change before sampling. Range 3..255; must cover the 2-flop synchronizer.
- SAMPLES, 16: number of o_in samples per code. Range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to run a calibration sweep; ignored while busy
- o_in  in  1  buffer output (asynchronous to clk); synchronized internally by 2 flops
- osc  out  4  offset code to the buffer. Bit 3 is the sign (1 = positive); bits [2:0] are the magnitude, in steps of 5 units.
- osc_en  out  1  calibration-mode enable to the buffer
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the sweep ends
- cal_code  out  4  final trim code (same encoding as osc)
- cal_ok  out  1  last sweep found a trip point
- err_sat_lo  out  1  o_in was already high at the most negative code
- err_sat_hi  out  1  o_in never went high, even at the most positive code

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - osc=4'b1000 (zero offset), osc_en=0, busy=0, done=0.
  - cal_code=4'b1000, cal_ok=0, err_sat_lo=0, err_sat_hi=0.
  - Synchronizer flops and counters cleared.
  - Reset mid-sweep aborts immediately; no done pulse is produced.
- Step index i runs 0..14:
  - value = i-7.
  - osc = {i>=7, |i-7|[2:0]}.
  - So i=0 gives 4'b0111 (-35), i=7 gives 4'b1000 (0), i=14 gives 4'b1111 (+35).
  - The negative-zero code 4'b0000 is never driven.
- States:
  - IDLE: osc_en=0. On start, go to SETTLE with i=0, osc=code(0), osc_en=1, busy=1. Also clear cal_ok and both err flags.
  - SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE.
  - SAMPLE: for SAMPLES cycles, add the synchronized o_in to ones (8-bit counter), then go to EVAL.
  - EVAL (1 cycle): hit = (2*ones >= SAMPLES), computed 9 bits wide; a tie counts as hit.
    - hit and i==0: err_sat_lo=1, cal_code=code(0). Go to FINISH.
    - hit and i>0: cal_ok=1, cal_code=code(i). Go to FINISH.
    - not hit and i==14: err_sat_hi=1, cal_code=code(14). Go to FINISH.
    - otherwise: i++, osc=code(i+1), clear ones. Go to SETTLE.
  - FINISH (1 cycle): done=1, busy=0, osc_en=0, osc=cal_code. Go to IDLE.
- Per-step latency is SETTLE_CYCLES+SAMPLES+1 cycles.
- A full sweep with no trip takes 15 steps plus 2 cycles (start-accept cycle and FINISH).
- osc changes only on SETTLE entry and in FINISH. osc_en is stable for the entire sweep.
- cal_code and the flags hold until the next start.
- start in the same cycle as done: ignored. A new sweep needs start while in IDLE.
- Exactly one of cal_ok, err_sat_lo and err_sat_hi is set after each sweep.

Test Plan:
- Buffer model with offset +12 (o_in = (12+5·signed(osc))>0) → trips at i=5: done with cal_code=4'b0010, cal_ok=1, osc=4'b0010, osc_en=0.
- Model offset +40 → err_sat_lo=1, cal_code=4'b0111, done exactly 27 cycles after start (defaults).
- Model offset -40 → err_sat_hi=1, cal_code=4'b1111, done 15·25+2=377 cycles after start. Check the osc sequence is 0111,0110,…,0001,1000,1001,…,1111.
- Noisy o_in at the crossing (step i=7 yields exactly 8 ones of 16) → tie counts as hit: cal_code=4'b1000, cal_ok=1.
- rst_n pulsed low at step 4 → outputs return to reset values asynchronously, no done pulse. A fresh start then sweeps from i=0.
- start re-pulsed while busy and on the done cycle → ignored. cal_code is unchanged until a start issued in IDLE.

Source files
------------

// File: rtl/ibuf_offset_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ibuf_offset_cal                                               |
// | Description : Input-buffer offset trim sweep; finds the comparator trip     |
// |               code and holds it for normal operation.                       |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module ibuf_offset_cal #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       o_in,
  output logic [3:0] osc,
  output logic       osc_en,
  output logic       busy,
  output logic       done,
  output logic [3:0] cal_code,
  output logic       cal_ok,
  output logic       err_sat_lo,
  output logic       err_sat_hi
);

  localparam logic [3:0] c_CODE_ZERO   = 4'b1000;
  localparam logic [3:0] c_IDX_FIRST   = 4'd0;
  localparam logic [3:0] c_IDX_LAST    = 4'd14;
  localparam logic [7:0] c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] c_SAMPLE_LAST = 8'(SAMPLES - 1);
  localparam logic [8:0] c_SAMPLES_9   = 9'(SAMPLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_EVAL   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_sync;
  logic [3:0] r_idx;
  logic [7:0] r_cnt;
  logic [7:0] r_ones;
  logic [3:0] r_osc;
  logic [3:0] r_cal_code;
  logic       r_osc_en;
  logic       r_busy;
  logic       r_done;
  logic       r_cal_ok;
  logic       r_err_lo;
  logic       r_err_hi;
  logic       w_hit;

  // Step index 0..14 maps to signed offset idx-7 in sign/magnitude; 4'b0000 never appears.
  function automatic logic [3:0] f_code(input logic [3:0] idx);
    if (idx >= 4'd7) begin
      return {1'b1, 3'(idx - 4'd7)};
    end else begin
      return {1'b0, 3'(4'd7 - idx)};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], o_in};
    end
  end

  // Majority vote with ties resolved as a trip.
  assign w_hit = ({r_ones, 1'b0} >= c_SAMPLES_9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= 4'd0;
      r_cnt      <= 8'd0;
      r_ones     <= 8'd0;
      r_osc      <= c_CODE_ZERO;
      r_cal_code <= c_CODE_ZERO;
      r_osc_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cal_ok   <= 1'b0;
      r_err_lo   <= 1'b0;
      r_err_hi   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SETTLE;
            r_idx    <= c_IDX_FIRST;
            r_cnt    <= 8'd0;
            r_ones   <= 8'd0;
            r_osc    <= f_code(c_IDX_FIRST);
            r_osc_en <= 1'b1;
            r_busy   <= 1'b1;
            r_cal_ok <= 1'b0;
            r_err_lo <= 1'b0;
            r_err_hi <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          r_ones <= r_ones + {7'd0, r_sync[1]};
          if (r_cnt == c_SAMPLE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= ST_EVAL;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_EVAL: begin
          if (w_hit || (r_idx == c_IDX_LAST)) begin
            // The FINISH-cycle outputs are loaded here so they are visible for that whole cycle.
            r_cal_code <= f_code(r_idx);
            r_osc      <= f_code(r_idx);
            r_cal_ok   <= w_hit && (r_idx != c_IDX_FIRST);
            r_err_lo   <= w_hit && (r_idx == c_IDX_FIRST);
            r_err_hi   <= !w_hit;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_osc_en   <= 1'b0;
            r_state    <= ST_FINISH;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_osc   <= f_code(r_idx + 4'd1);
            r_ones  <= 8'd0;
            r_state <= ST_SETTLE;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign osc        = r_osc;
  assign osc_en     = r_osc_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cal_code   = r_cal_code;
  assign cal_ok     = r_cal_ok;
  assign err_sat_lo = r_err_lo;
  assign err_sat_hi = r_err_hi;

endmodule
`default_nettype wire

// File: tb/tb_ibuf_offset_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ibuf_offset_cal                                            |
// | Description : Directed bench with a behavioural buffer model for the sweep. |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_ibuf_offset_cal;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       o_in;
  logic [3:0] osc;
  logic       osc_en;
  logic       busy;
  logic       done;
  logic [3:0] cal_code;
  logic       cal_ok;
  logic       err_sat_lo;
  logic       err_sat_hi;

  int n_checks = 0;
  int n_fail   = 0;

  int   model_off = 0;
  bit   noise_en  = 1'b0;
  logic r_tog     = 1'b0;
  int   en_drop;
  logic [3:0] osc_seq[$];

  typedef struct {
    int         off;
    bit         noise;
    logic [3:0] code;
    logic       ok;
    logic       lo;
    logic       hi;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  ibuf_offset_cal #(.SETTLE_CYCLES(8), .SAMPLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .o_in       (o_in),
    .osc        (osc),
    .osc_en     (osc_en),
    .busy       (busy),
    .done       (done),
    .cal_code   (cal_code),
    .cal_ok     (cal_ok),
    .err_sat_lo (err_sat_lo),
    .err_sat_hi (err_sat_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer trips when its own offset plus 5 units per code step is positive.
  function automatic logic buf_model(input logic [3:0] code, input int off);
    int mag;
    int val;
    mag = int'(code[2:0]);
    val = code[3] ? mag : -mag;
    return ((off + 5 * val) > 0);
  endfunction

  always @(negedge clk) begin
    r_tog = ~r_tog;
    if (noise_en && (osc == 4'b1000)) o_in = r_tog;
    else                              o_in = buf_model(osc, model_off);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // lat counts inclusively from the start cycle to the done cycle.
  task automatic run_sweep(input int off, input bit nz, input bit poke,
                           output int lat, output bit seen);
    logic [3:0] prev;
    prev      = 4'b0000;
    model_off = off;
    noise_en  = nz;
    osc_seq.delete();
    en_drop = 0;
    seen    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    lat   = 1;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (poke && (lat == 60)) start = 1'b1;
      if (busy && !osc_en) en_drop++;
      if (busy && ((osc_seq.size() == 0) || (osc != prev))) begin
        osc_seq.push_back(osc);
        prev = osc;
      end
      if (done) begin
        seen = 1'b1;
        if (poke) start = 1'b1;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input bit seen);
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " latency"}, lat, v.lat);
    check({tag, " cal_code"}, int'(cal_code), int'(v.code));
    check({tag, " cal_ok"}, int'(cal_ok), int'(v.ok));
    check({tag, " err_sat_lo"}, int'(err_sat_lo), int'(v.lo));
    check({tag, " err_sat_hi"}, int'(err_sat_hi), int'(v.hi));
    check({tag, " osc_final"}, int'(osc), int'(v.code));
    check({tag, " osc_en_final"}, int'(osc_en), 0);
    check({tag, " busy_final"}, int'(busy), 0);
    check({tag, " osc_en_drop"}, en_drop, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " osc"}, int'(osc), 'h8);
    check({tag, " osc_en"}, int'(osc_en), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " cal_code"}, int'(cal_code), 'h8);
    check({tag, " cal_ok"}, int'(cal_ok), 0);
    check({tag, " err_sat_lo"}, int'(err_sat_lo), 0);
    check({tag, " err_sat_hi"}, int'(err_sat_hi), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         seen;
    int         stray;
    bit         found;
    logic [3:0] exp_seq[15];

    // Trip at step i gives latency (i+1)*25+2.
    vecs[0] = '{off:  12, noise: 1'b0, code: 4'b0010, ok: 1'b1, lo: 1'b0, hi: 1'b0, lat: 152};
    vecs[1] = '{off:  40, noise: 1'b0, code: 4'b0111, ok: 1'b0, lo: 1'b1, hi: 1'b0, lat:  27};
    vecs[2] = '{off: -40, noise: 1'b0, code: 4'b1111, ok: 1'b0, lo: 1'b0, hi: 1'b1, lat: 377};
    vecs[3] = '{off:   0, noise: 1'b1, code: 4'b1000, ok: 1'b1, lo: 1'b0, hi: 1'b0, lat: 202};
    vecs[4] = '{off:   0, noise: 1'b0, code: 4'b1001, ok: 1'b1, lo: 1'b0, hi: 1'b0, lat: 227};
    vecs[5] = '{off: -12, noise: 1'b0, code: 4'b1011, ok: 1'b1, lo: 1'b0, hi: 1'b0, lat: 277};
    vecs[6] = '{off:   3, noise: 1'b0, code: 4'b1000, ok: 1'b1, lo: 1'b0, hi: 1'b0, lat: 202};

    exp_seq = '{4'b0111, 4'b0110, 4'b0101, 4'b0100, 4'b0011, 4'b0010, 4'b0001,
                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};

    rst_n = 1'b0;
    start = 1'b0;
    o_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      string tag;
      logic [3:0] held;
      tag = $sformatf("vec%0d", v);
      run_sweep(vecs[v].off, vecs[v].noise, 1'b0, lat, seen);
      check_result(tag, vecs[v], lat, seen);
      held = cal_code;
      @(posedge clk);
      #1;
      check({tag, " done_one_cycle"}, int'(done), 0);
      check({tag, " cal_code_held"}, int'(cal_code), int'(held));
      if (v == 2) begin
        check("osc_seq length", osc_seq.size(), 15);
        for (int j = 0; j < 15 && j < osc_seq.size(); j++)
          check($sformatf("osc_seq[%0d]", j), int'(osc_seq[j]), int'(exp_seq[j]));
      end
      repeat (2) @(negedge clk);
    end

    // start pulsed mid-sweep and again during the done cycle: both must be ignored.
    run_sweep(-12, 1'b0, 1'b1, lat, seen);
    check_result("poke", vecs[5], lat, seen);
    @(posedge clk);
    #1;
    start = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy || done || osc_en) stray++;
      @(posedge clk);
      #1;
    end
    check("poke start_on_done_ignored", stray, 0);
    check("poke cal_code_held", int'(cal_code), 'hB);
    check("poke cal_ok_held", int'(cal_ok), 1);

    // Asynchronous reset partway through step 4 of a sweep.
    model_off = -40;
    noise_en  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge clk);
      #1;
      if (osc == 4'b0011) found = 1'b1;
    end
    check("rst step4 reached", int'(found), 1);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    check("rst no_done_after_abort", stray, 0);
    run_sweep(12, 1'b0, 1'b0, lat, seen);
    check("rst fresh first_osc", (osc_seq.size() > 0) ? int'(osc_seq[0]) : -1, 'h7);
    check_result("rst_fresh", vecs[0], lat, seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
